// File: rtl/imem_load_ctrl_if.sv
// Bus between the instruction-memory load controller and its neighbours:
// debug loader byte stream, IF fetch address, and the memory port.
interface imem_load_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic              load_abort;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [31:0]       fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              if_stall;
  logic              busy;
  logic              done;
  logic              full;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output load_start, load_base, load_abort, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_addr, mem_we, mem_wdata, if_stall, busy, done, full,
           words_loaded
  );

  modport slave (
    input  load_start, load_base, load_abort, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_addr, mem_we, mem_wdata, if_stall, busy, done, full,
           words_loaded
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Shares the single-port instruction memory between IF fetch and a byte-serial
// program loader; bytes are packed big-endian and written to consecutive words.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | fetch owns the memory; waiting for load_start
// S_RECV  | IF stalled; collecting 4 bytes into the shift register
// S_WRITE | one-cycle write of the assembled word at wr_ptr
// S_DONE  | one-cycle done pulse, IF still stalled
module imem_load_ctrl #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic           clk,
  input  logic           reset_n,
  imem_load_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  logic [31:0]       shreg;
  logic [ADDR_W:0]   words_loaded;
  logic              full;
  logic              byte_acc;
  logic              at_last;
  logic              is_halt;
  logic              unused_fetch;

  // abort wins over a byte offered in the same cycle
  assign byte_acc     = (state == S_RECV) && bus.byte_valid && !bus.load_abort;
  assign at_last      = (wr_ptr == LAST_PTR);
  assign is_halt      = (shreg == HALT_WORD);
  assign unused_fetch = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.load_start) state_nxt = S_RECV;
      end
      S_RECV: begin
        if (bus.load_abort) begin
          state_nxt = S_IDLE;
        end else if (bus.byte_valid && (byte_cnt == 2'd3)) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (is_halt || at_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RECV;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      words_loaded <= '0;
      full         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.load_start) begin
            wr_ptr       <= bus.load_base;
            byte_cnt     <= '0;
            words_loaded <= '0;
            full         <= 1'b0;
          end
        end
        S_RECV: begin
          if (byte_acc) begin
            shreg    <= {shreg[23:0], bus.byte_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          // the last word of memory ends the load even when it is the halt word
          if (at_last) full <= 1'b1;
          if (!is_halt && !at_last) begin
            wr_ptr   <= wr_ptr + ADDR_W'(1);
            byte_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr   = wr_ptr;
    bus.mem_we     = 1'b0;
    bus.byte_ready = 1'b0;
    bus.if_stall   = 1'b1;
    bus.busy       = 1'b1;
    bus.done       = 1'b0;
    case (state)
      S_IDLE: begin
        bus.mem_addr = bus.fetch_addr[ADDR_W+1:2];
        bus.if_stall = 1'b0;
        bus.busy     = 1'b0;
      end
      S_RECV:  bus.byte_ready = 1'b1;
      S_WRITE: bus.mem_we     = 1'b1;
      S_DONE:  bus.done       = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_wdata    = shreg;
  assign bus.words_loaded = words_loaded;
  assign bus.full         = full;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: table-driven fetch/load vectors, hand-written abort
// and reset sequences, and randomized loads scored against a word-list model.
module tb_imem_load_ctrl;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  imem_load_ctrl_if #(.ADDR_W(8)) bus ();

  imem_load_ctrl #(.DEPTH(256), .ADDR_W(8), .HALT_WORD(HALT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] fa;
    logic [7:0]  exp_ma;
  } fetch_vec_t;

  typedef struct {
    logic [7:0]        base;
    int                nw;
    logic [3:0][31:0]  w;
    int                gap_mode;
    bit                inj_recv;
    bit                inj_done;
    int                exp_wl;
    bit                exp_full;
  } load_vec_t;

  int total = 0;
  int bad   = 0;

  logic [31:0] stim_w[$];
  int          stim_gap[$];
  logic [39:0] exp_wr[$];
  logic [39:0] got_wr[$];
  int          done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fill_gaps(input int mode);
    stim_gap.delete();
    for (int j = 0; j < stim_w.size() * 4; j++)
      stim_gap.push_back(mode == 0 ? 0 : (mode == 1 ? 1 : int'($urandom_range(0, 2))));
  endtask

  // Word-list view of a load: consecutive addresses from base, stop after the
  // halt word or after writing the last word; each word costs 4 byte cycles,
  // its gaps and one write cycle, plus the done cycle at the end.
  task automatic model(input logic [7:0] base, output int wl, output bit fl, output int cycles);
    logic [7:0] ptr;
    ptr = base;
    wl = 0;
    fl = 0;
    cycles = 1;
    exp_wr.delete();
    for (int i = 0; i < stim_w.size(); i++) begin
      exp_wr.push_back({ptr, stim_w[i]});
      wl++;
      cycles += 5;
      for (int k = 0; k < 4; k++) cycles += stim_gap[4*i+k];
      if (ptr == 8'hFF) fl = 1;
      if (stim_w[i] == HALT || ptr == 8'hFF) break;
      ptr++;
    end
  endtask

  task automatic cycle_drive(input bit v, input logic [7:0] d, input bit ab, input bit st,
                             input logic [7:0] b);
    @(negedge clk);
    if (bus.mem_we) got_wr.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.done) done_cnt++;
    bus.byte_valid = v;
    bus.byte_data  = d;
    bus.load_abort = ab;
    bus.load_start = st;
    bus.load_base  = b;
  endtask

  task automatic run_load(input logic [7:0] base, input bit inj_recv, input bit inj_done,
                          input int exp_wl, input bit exp_full, input string tag);
    int m_wl, exp_cyc, idx, gap_left, cyc, nbytes, done_at, stall_bad, n;
    bit m_fl, injected, timeout;
    model(base, m_wl, m_fl, exp_cyc);
    got_wr.delete();
    done_cnt = 0; done_at = -1; stall_bad = 0;
    nbytes = stim_w.size() * 4;
    idx = 0; gap_left = stim_gap[0]; injected = 0; timeout = 1;
    @(negedge clk);
    bus.load_start = 1'b1; bus.load_base = base; bus.byte_valid = 1'b0; bus.load_abort = 1'b0;
    cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      cyc++;
      bus.load_start = 1'b0;
      if (!bus.busy) begin timeout = 0; break; end
      if (bus.mem_we) got_wr.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.done) begin
        done_cnt++;
        done_at = cyc;
        if (inj_done) begin bus.load_start = 1'b1; bus.load_base = 8'h33; end
      end
      if (!bus.if_stall) stall_bad++;
      if (inj_recv && !injected && idx == 2 && bus.byte_ready) begin
        bus.load_start = 1'b1; bus.load_base = 8'h77; injected = 1;
      end
      if (idx < nbytes && gap_left == 0) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'(stim_w[idx/4] >> (24 - 8*(idx%4)));
      end else begin
        bus.byte_valid = 1'b0;
      end
      if (bus.byte_ready) begin
        if (bus.byte_valid) begin
          idx++;
          gap_left = (idx < nbytes) ? stim_gap[idx] : 0;
        end else if (gap_left > 0) begin
          gap_left--;
        end
      end
    end
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
    chk({tag, " timeout"}, 64'(timeout), 64'd0);
    chk({tag, " write count"}, 64'(got_wr.size()), 64'(exp_wr.size()));
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s write[%0d] addr:data", tag, i), 64'(got_wr[i]), 64'(exp_wr[i]));
    chk({tag, " done count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done cycle"}, 64'(done_at), 64'(exp_cyc));
    chk({tag, " stall while busy"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    chk({tag, " words_loaded"}, 64'(bus.words_loaded), 64'(exp_wl));
    chk({tag, " full"}, 64'(bus.full), 64'(exp_full));
    chk({tag, " busy after"}, 64'(bus.busy), 64'd0);
    chk({tag, " if_stall after"}, 64'(bus.if_stall), 64'd0);
  endtask

  fetch_vec_t fv[6];
  load_vec_t  lv[7];

  initial begin
    int wl, cyc;
    bit fl;
    logic [7:0] base;
    int n;

    fv[0] = '{32'h0000_0010, 8'h04};
    fv[1] = '{32'h0000_0003, 8'h00};
    fv[2] = '{32'hFFFF_FFFC, 8'hFF};
    fv[3] = '{32'h1234_5678, 8'h9E};
    fv[4] = '{32'h0000_0400, 8'h00};
    fv[5] = '{32'h0000_03FF, 8'hFF};

    lv[0] = '{8'h00, 2, {32'h0, 32'h0, HALT, 32'h2008_0005}, 0, 0, 0, 2, 0};
    lv[1] = '{8'h00, 2, {32'h0, 32'h0, HALT, 32'h2008_0005}, 1, 0, 0, 2, 0};
    lv[2] = '{8'hFE, 3, {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, 0, 2, 1};
    lv[3] = '{8'hFF, 1, {32'h0, 32'h0, 32'h0, HALT}, 0, 0, 0, 1, 1};
    lv[4] = '{8'h40, 3, {32'h0, HALT, 32'h0000_0000, 32'hA5A5_A5A5}, 0, 1, 0, 3, 0};
    lv[5] = '{8'h80, 3, {32'h0, HALT, 32'hDEAD_BEEF, 32'h1234_5678}, 0, 0, 1, 3, 0};
    lv[6] = '{8'h00, 2, {32'h0, 32'h0, HALT, 32'hFFFF_FFFE}, 2, 0, 0, 2, 0};

    bus.load_start = 1'b0; bus.load_base = 8'h00; bus.load_abort = 1'b0;
    bus.byte_valid = 1'b1; bus.byte_data = 8'h5A; bus.fetch_addr = 32'h0000_0010;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst if_stall", 64'(bus.if_stall), 64'd0);
    chk("rst mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst words_loaded", 64'(bus.words_loaded), 64'd0);
    chk("rst mem_addr", 64'(bus.mem_addr), 64'h04);
    chk("rst busy/done/full", 64'({bus.busy, bus.done, bus.full}), 64'd0);
    chk("rst mem_wdata", 64'(bus.mem_wdata), 64'd0);
    bus.byte_valid = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.fetch_addr = fv[i].fa;
      #1;
      chk($sformatf("fetch mem_addr[%0d]", i), 64'(bus.mem_addr), 64'(fv[i].exp_ma));
      chk($sformatf("fetch mem_we[%0d]", i), 64'(bus.mem_we), 64'd0);
    end
    bus.fetch_addr = 32'h0000_0100;

    for (int i = 0; i < 7; i++) begin
      stim_w.delete();
      for (int k = 0; k < lv[i].nw; k++) stim_w.push_back(lv[i].w[k]);
      fill_gaps(lv[i].gap_mode);
      run_load(lv[i].base, lv[i].inj_recv, lv[i].inj_done, lv[i].exp_wl, lv[i].exp_full,
               $sformatf("vec%0d", i));
    end

    // abort after one full word plus two bytes, byte offered with the abort
    got_wr.delete(); done_cnt = 0;
    cycle_drive(0, 8'h00, 0, 1, 8'h10);
    cycle_drive(1, 8'h01, 0, 0, 8'h00);
    cycle_drive(1, 8'h02, 0, 0, 8'h00);
    cycle_drive(1, 8'h03, 0, 0, 8'h00);
    cycle_drive(1, 8'h04, 0, 0, 8'h00);
    cycle_drive(0, 8'h00, 0, 0, 8'h00);
    cycle_drive(1, 8'hAA, 0, 0, 8'h00);
    cycle_drive(1, 8'hBB, 0, 0, 8'h00);
    cycle_drive(1, 8'hCC, 1, 0, 8'h00);
    cycle_drive(0, 8'h00, 0, 0, 8'h00);
    chk("abort busy next cycle", 64'(bus.busy), 64'd0);
    chk("abort byte_ready", 64'(bus.byte_ready), 64'd0);
    cycle_drive(0, 8'h00, 0, 0, 8'h00);
    chk("abort write count", 64'(got_wr.size()), 64'd1);
    if (got_wr.size() > 0) chk("abort first write", 64'(got_wr[0]), 64'({8'h10, 32'h0102_0304}));
    chk("abort done count", 64'(done_cnt), 64'd0);
    chk("abort words_loaded", 64'(bus.words_loaded), 64'd1);

    // reset lands on the edge that would accept the fourth byte
    got_wr.delete(); done_cnt = 0;
    cycle_drive(0, 8'h00, 0, 1, 8'h20);
    cycle_drive(1, 8'h11, 0, 0, 8'h00);
    cycle_drive(1, 8'h22, 0, 0, 8'h00);
    cycle_drive(1, 8'h33, 0, 0, 8'h00);
    cycle_drive(1, 8'h44, 0, 0, 8'h00);
    reset_n = 1'b0;
    cycle_drive(0, 8'h00, 0, 0, 8'h00);
    chk("midrst outputs", 64'({bus.byte_ready, bus.mem_we, bus.if_stall, bus.busy, bus.done, bus.full}), 64'd0);
    chk("midrst words_loaded", 64'(bus.words_loaded), 64'd0);
    chk("midrst mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("midrst mem_addr", 64'(bus.mem_addr), 64'(bus.fetch_addr[9:2]));
    chk("midrst no write", 64'(got_wr.size()), 64'd0);
    reset_n = 1'b1;

    for (int r = 0; r < 25; r++) begin
      base = $urandom_range(0, 1) ? 8'($urandom_range(248, 255)) : 8'($urandom_range(0, 255));
      n = $urandom_range(1, 6);
      stim_w.delete();
      for (int k = 0; k < n; k++) stim_w.push_back(($urandom_range(0, 3) == 0) ? HALT : $urandom());
      stim_w.push_back(HALT);
      fill_gaps(2);
      model(base, wl, fl, cyc);
      run_load(base, 0, 0, wl, fl, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
